// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I subset core with separate instruction and data buses.
// The registered next-PC gives one architectural branch delay slot; PC == 0 halts the core.
module mips_cpu_harvard_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [31:0] pc;
    logic [31:0] npc;
    logic        active_r;
    logic [31:0] gpr [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        taken;
    logic [31:0] target;
    logic        is_lw;
    logic        is_sw;
    logic        execute;

    assign opcode        = instr_readdata[31:26];
    assign rs            = instr_readdata[25:21];
    assign rt            = instr_readdata[20:16];
    assign rd            = instr_readdata[15:11];
    assign shamt         = instr_readdata[10:6];
    assign funct         = instr_readdata[5:0];
    assign rs_val        = (rs == 5'd0) ? 32'h0 : gpr[rs];
    assign rt_val        = (rt == 5'd0) ? 32'h0 : gpr[rt];
    assign imm_sext      = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign imm_zext      = {16'h0, instr_readdata[15:0]};
    assign pc_plus4      = pc + 32'd4;
    assign pc_plus8      = pc + 32'd8;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = 32'h0;
        taken   = 1'b0;
        target  = branch_target;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                wr_en   = 1'b1;
                wr_addr = rd;
                case (funct)
                    FN_SLL:  wr_data = rt_val << shamt;
                    FN_SRL:  wr_data = rt_val >> shamt;
                    FN_SRA:  wr_data = $unsigned($signed(rt_val) >>> shamt);
                    FN_SLLV: wr_data = rt_val << rs_val[4:0];
                    FN_SRLV: wr_data = rt_val >> rs_val[4:0];
                    FN_SRAV: wr_data = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                    FN_ADDU: wr_data = rs_val + rt_val;
                    FN_SUBU: wr_data = rs_val - rt_val;
                    FN_AND:  wr_data = rs_val & rt_val;
                    FN_OR:   wr_data = rs_val | rt_val;
                    FN_XOR:  wr_data = rs_val ^ rt_val;
                    FN_NOR:  wr_data = ~(rs_val | rt_val);
                    FN_SLT:  wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: wr_data = {31'h0, rs_val < rt_val};
                    FN_JR: begin
                        wr_en  = 1'b0;
                        taken  = 1'b1;
                        target = {rs_val[31:2], 2'b00};
                    end
                    FN_JALR: begin
                        taken   = 1'b1;
                        target  = {rs_val[31:2], 2'b00};
                        wr_data = pc_plus8;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_J: begin
                taken  = 1'b1;
                target = jump_target;
            end
            OP_JAL: begin
                taken   = 1'b1;
                target  = jump_target;
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = pc_plus8;
            end
            OP_BEQ:  taken = (rs_val == rt_val);
            OP_BNE:  taken = (rs_val != rt_val);
            OP_BLEZ: taken = ($signed(rs_val) <= 0);
            OP_BGTZ: taken = ($signed(rs_val) > 0);
            OP_ADDIU: begin
                wr_en   = 1'b1;
                wr_data = rs_val + imm_sext;
            end
            OP_SLTI: begin
                wr_en   = 1'b1;
                wr_data = {31'h0, $signed(rs_val) < $signed(imm_sext)};
            end
            OP_SLTIU: begin
                wr_en   = 1'b1;
                wr_data = {31'h0, rs_val < imm_sext};
            end
            OP_ANDI: begin
                wr_en   = 1'b1;
                wr_data = rs_val & imm_zext;
            end
            OP_ORI: begin
                wr_en   = 1'b1;
                wr_data = rs_val | imm_zext;
            end
            OP_XORI: begin
                wr_en   = 1'b1;
                wr_data = rs_val ^ imm_zext;
            end
            OP_LUI: begin
                wr_en   = 1'b1;
                wr_data = {instr_readdata[15:0], 16'h0};
            end
            OP_LW: begin
                is_lw   = 1'b1;
                wr_en   = 1'b1;
                wr_data = data_readdata;
            end
            OP_SW:   is_sw = 1'b1;
            default: ;
        endcase
    end

    // An instruction only has side effects on an edge that will actually retire it.
    assign execute        = active_r && clk_enable && reset && (pc != 32'h0);
    assign data_write     = execute && is_sw;
    assign data_read      = execute && is_lw;
    assign data_address   = rs_val + imm_sext;
    assign data_writedata = rt_val;
    assign instr_address  = pc;
    assign active         = active_r;
    assign register_v0    = gpr[2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= RESET_VECTOR;
            npc      <= RESET_VECTOR + 32'd4;
            active_r <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= 32'h0;
            end
        end else if (clk_enable && active_r) begin
            if (pc == 32'h0) begin
                active_r <= 1'b0;
            end else begin
                pc  <= npc;
                npc <= taken ? target : (npc + 32'd4);
                if (wr_en && (wr_addr != 5'd0)) begin
                    gpr[wr_addr] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Bench for mips_cpu_harvard_core: instruction-level reference model checked every cycle,
// directed programs with literal results, and random programs with random stalls and resets.
module tb_mips_cpu_harvard_core;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    mips_cpu_harvard_core #(.RESET_VECTOR(RV)) dut (
        .clk(clk),
        .reset(reset),
        .active(active),
        .register_v0(register_v0),
        .clk_enable(clk_enable),
        .instr_address(instr_address),
        .instr_readdata(instr_readdata),
        .data_address(data_address),
        .data_write(data_write),
        .data_read(data_read),
        .data_writedata(data_writedata),
        .data_readdata(data_readdata)
    );

    logic [31:0] imem [256];
    logic [31:0] dmem [1024];
    logic [31:0] mmem [1024];

    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic        m_active;
    logic [31:0] m_regs [32];

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    bit chk_en   = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fetch(input logic [31:0] a);
        if (a[31:10] == 22'h2FF000) return imem[a[9:2]];
        return 32'h0;
    endfunction

    assign instr_readdata = fetch(instr_address);
    assign data_readdata  = dmem[data_address[11:2]];

    function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
        return {op, 5'(s), 5'(t), imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input int idx);
        logic [31:0] addr;
        addr = RV + 32'(idx * 4);
        return {op, addr[27:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-set-level model: one call per rising edge.
    task automatic model_edge();
        logic [31:0] ins, a, b, se, ze, val, nxt, pc4, adr;
        logic [4:0]  rs, rt, rd, sh;
        int dest;
        if (!reset) begin
            m_pc = RV;
            m_npc = RV + 4;
            m_active = 1;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
        end else if (clk_enable && m_active) begin
            if (m_pc == 0) begin
                m_active = 0;
            end else begin
                ins = fetch(m_pc);
                rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
                a = m_regs[rs]; b = m_regs[rt];
                se = {{16{ins[15]}}, ins[15:0]};
                ze = {16'h0, ins[15:0]};
                pc4 = m_pc + 4;
                adr = a + se;
                nxt = m_npc + 4;
                dest = -1;
                val = 0;
                case (ins[31:26])
                    6'h00: begin
                        dest = rd;
                        case (ins[5:0])
                            6'h00: val = b << sh;
                            6'h02: val = b >> sh;
                            6'h03: val = $signed(b) >>> sh;
                            6'h04: val = b << a[4:0];
                            6'h06: val = b >> a[4:0];
                            6'h07: val = $signed(b) >>> a[4:0];
                            6'h08: begin dest = -1; nxt = a & ~32'h3; end
                            6'h09: begin nxt = a & ~32'h3; val = m_pc + 8; end
                            6'h21: val = a + b;
                            6'h23: val = a - b;
                            6'h24: val = a & b;
                            6'h25: val = a | b;
                            6'h26: val = a ^ b;
                            6'h27: val = ~(a | b);
                            6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                            6'h2B: val = (a < b) ? 32'd1 : 32'd0;
                            default: dest = -1;
                        endcase
                    end
                    6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
                    6'h03: begin nxt = {pc4[31:28], ins[25:0], 2'b00}; dest = 31; val = m_pc + 8; end
                    6'h04: if (a == b) nxt = pc4 + (se << 2);
                    6'h05: if (a != b) nxt = pc4 + (se << 2);
                    6'h06: if ($signed(a) <= 0) nxt = pc4 + (se << 2);
                    6'h07: if ($signed(a) > 0) nxt = pc4 + (se << 2);
                    6'h09: begin dest = rt; val = a + se; end
                    6'h0A: begin dest = rt; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
                    6'h0B: begin dest = rt; val = (a < se) ? 32'd1 : 32'd0; end
                    6'h0C: begin dest = rt; val = a & ze; end
                    6'h0D: begin dest = rt; val = a | ze; end
                    6'h0E: begin dest = rt; val = a ^ ze; end
                    6'h0F: begin dest = rt; val = {ins[15:0], 16'h0}; end
                    6'h23: begin dest = rt; val = mmem[adr[11:2]]; end
                    6'h2B: mmem[adr[11:2]] = b;
                    default: ;
                endcase
                if (dest > 0) m_regs[dest] = val;
                m_pc = m_npc;
                m_npc = nxt;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Per-cycle comparison against the model, plus the external data memory write port.
    initial begin
        logic [31:0] ins, exp_addr;
        bit ex, ew, er;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("pc", instr_address, m_pc);
                check("active", {31'h0, active}, {31'h0, m_active});
                check("v0", register_v0, m_regs[2]);
                ins = fetch(m_pc);
                ex = reset && clk_enable && m_active && (m_pc != 0);
                ew = ex && (ins[31:26] == 6'h2B);
                er = ex && (ins[31:26] == 6'h23);
                exp_addr = m_regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
                check("data_write", {31'h0, data_write}, {31'h0, ew});
                check("data_read", {31'h0, data_read}, {31'h0, er});
                if (ew || er) check("data_address", data_address, exp_addr);
                if (ew) check("data_writedata", data_writedata, m_regs[ins[20:16]]);
            end
            if (data_write) begin
                dmem[data_address[11:2]] = data_writedata;
                wr_count++;
            end
        end
    end

    // mode 0: always enabled; 1: 3-cycle stall from s0; 2: random enable; 3: random enable + reset at s0
    task automatic run_prog(input int budget, input int mode, input int s0, output int halt_cyc);
        int cnt;
        halt_cyc = -1;
        @(posedge clk); #2;
        reset = 0;
        clk_enable = 1;
        @(posedge clk); #2;
        reset = 1;
        chk_en = 1;
        wr_count = 0;
        check("rst_pc", instr_address, RV);
        check("rst_active", {31'h0, active}, 32'h1);
        check("rst_v0", register_v0, 32'h0);
        cnt = 0;
        while (cnt < budget && (m_active || active)) begin
            case (mode)
                1: clk_enable = (cnt >= s0 && cnt < s0 + 3) ? 1'b0 : 1'b1;
                2: clk_enable = ($urandom_range(0, 4) != 0);
                3: begin
                    clk_enable = ($urandom_range(0, 4) != 0);
                    reset = (cnt == s0) ? 1'b0 : 1'b1;
                end
                default: clk_enable = 1;
            endcase
            @(posedge clk); #2;
            cnt++;
            if (!active && halt_cyc < 0) halt_cyc = cnt;
        end
        reset = 1;
        clk_enable = 1;
        check("halted", {31'h0, active}, 32'h0);
    endtask

    task automatic clear_mem();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) imem[i] = 0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            dmem[i] = v;
            mmem[i] = v;
        end
    endtask

    function automatic logic [31:0] rand_plain();
        logic [5:0] fns [16];
        logic [5:0] ops [10];
        int k;
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h21, 6'h23};
        ops = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        k = $urandom_range(0, 1);
        if (k == 0)
            return r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 31), fns[$urandom_range(0, 15)]);
        return i_ins(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7),
                     16'($urandom));
    endfunction

    task automatic gen_random(input int len);
        logic [5:0] bops [4];
        bit prev_branch;
        int off, t;
        bops = '{6'h04, 6'h05, 6'h06, 6'h07};
        prev_branch = 0;
        for (int i = 0; i < len; i++) begin
            if (!prev_branch && i <= len - 2 && $urandom_range(0, 5) == 0) begin
                off = $urandom_range(1, len - i - 1);
                t = i + 1 + off;
                case ($urandom_range(0, 2))
                    0: imem[i] = j_ins(6'h02, t);
                    1: imem[i] = j_ins(6'h03, t);
                    default: imem[i] = i_ins(bops[$urandom_range(0, 3)], $urandom_range(0, 7),
                                             $urandom_range(0, 7), 16'(off));
                endcase
                prev_branch = 1;
            end else begin
                imem[i] = rand_plain();
                prev_branch = 0;
            end
        end
        imem[len]     = r_ins(0, 0, 0, 0, 6'h08);
        imem[len + 1] = 32'h0;
    endtask

    initial begin
        int hc;
        logic [31:0] jr0;
        reset = 0;
        clk_enable = 1;
        jr0 = r_ins(0, 0, 0, 0, 6'h08);

        // ADDIU $2,$0,5; JR $0; NOP
        clear_mem();
        imem[0] = i_ins(6'h09, 0, 2, 16'd5);
        imem[1] = jr0;
        run_prog(50, 0, 0, hc);
        check("addiu_v0", register_v0, 32'd5);
        check("halt_cycles", 32'(hc), 32'd4);

        // LUI/ORI
        clear_mem();
        imem[0] = i_ins(6'h0F, 0, 2, 16'h1234);
        imem[1] = i_ins(6'h0D, 2, 2, 16'h5678);
        imem[2] = jr0;
        run_prog(50, 0, 0, hc);
        check("lui_ori_v0", register_v0, 32'h1234_5678);

        // SW/LW round trip
        clear_mem();
        imem[0] = i_ins(6'h09, 0, 4, 16'h0100);
        imem[1] = i_ins(6'h09, 0, 3, 16'h0077);
        imem[2] = i_ins(6'h2B, 4, 3, 16'h0000);
        imem[3] = i_ins(6'h23, 4, 2, 16'h0000);
        imem[4] = jr0;
        run_prog(50, 0, 0, hc);
        check("swlw_v0", register_v0, 32'h77);
        check("swlw_writes", 32'(wr_count), 32'd1);

        // branch with delay slot
        clear_mem();
        imem[0] = i_ins(6'h04, 0, 0, 16'd2);
        imem[1] = i_ins(6'h09, 0, 2, 16'd1);
        imem[2] = i_ins(6'h09, 0, 2, 16'd9);
        imem[3] = jr0;
        run_prog(50, 0, 0, hc);
        check("beq_slot_v0", register_v0, 32'd1);

        // stall versus unstalled on a store/load program
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            imem[0] = i_ins(6'h09, 0, 2, 16'd7);
            imem[1] = i_ins(6'h09, 0, 3, 16'h0040);
            imem[2] = i_ins(6'h2B, 3, 2, 16'h0000);
            imem[3] = i_ins(6'h23, 3, 5, 16'h0000);
            imem[4] = r_ins(2, 5, 2, 0, 6'h21);
            imem[5] = jr0;
            run_prog(50, pass, 2, hc);
            check("stall_v0", register_v0, 32'd14);
            check("stall_writes", 32'(wr_count), 32'd1);
        end

        // wraparound without trap
        clear_mem();
        imem[0] = i_ins(6'h09, 0, 2, 16'hFFFF);
        imem[1] = i_ins(6'h09, 2, 2, 16'h0001);
        imem[2] = jr0;
        run_prog(50, 0, 0, hc);
        check("wrap_v0", register_v0, 32'h0);

        // JAL / JR $31
        clear_mem();
        imem[0] = j_ins(6'h03, 4);
        imem[1] = i_ins(6'h09, 0, 2, 16'd3);
        imem[2] = jr0;
        imem[4] = r_ins(2, 31, 2, 0, 6'h21);
        imem[5] = r_ins(31, 0, 0, 0, 6'h08);
        run_prog(50, 0, 0, hc);
        check("jal_v0", register_v0, 32'hBFC0_000B);

        // JALR
        clear_mem();
        imem[0] = i_ins(6'h0F, 0, 6, 16'hBFC0);
        imem[1] = i_ins(6'h0D, 6, 6, 16'h0018);
        imem[2] = r_ins(6, 0, 2, 0, 6'h09);
        imem[4] = jr0;
        imem[6] = jr0;
        run_prog(50, 0, 0, hc);
        check("jalr_v0", register_v0, 32'hBFC0_0010);

        // random programs
        for (int r = 0; r < 8; r++) begin
            clear_mem();
            gen_random(40);
            run_prog(600, (r == 3 || r == 6) ? 3 : ((r == 0) ? 0 : 2), 20, hc);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
